ex_div: RTL and testbench

- Multi-cycle RV32M divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered instruction, operands and destination from ID/EX.
- Executes DIV/DIVU/REM/REMU by 32-iteration restoring division on magnitudes.
- Stalls the front of the pipeline through hold_o, then issues a single-cycle register write-back.

---
 rtl/ex_div_pkg.sv | 28 ++
 rtl/ex_div_core.sv | 70 +++++++
 rtl/ex_div.sv | 139 +++++++++++++
 tb/tb_ex_div.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared decode constants, FSM state encoding and a helper for
// the divide unit in the execute stage.
//   - INST_TYPE_R_M / FUNCT7_M : R-type opcode and M-extension funct7
//   - F3_*                     : funct3 codes of DIV/DIVU/REM/REMU
//   - state_e                  : IDLE / CALC / DONE
//   - neg_if()                 : conditional two's-complement negate
package ex_div_pkg;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_M      = 7'b0000001;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Negation wraps modulo 2^32, so -0x80000000 stays 0x80000000.
    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] x);
        return n ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/ex_div_core.sv
// div_core: iterative restoring divider on unsigned magnitudes.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : load dividend/divisor and begin 2^CNT_W steps
//   kill_i       : abandon the running division
//   dividend_i   : unsigned dividend magnitude
//   divisor_i    : unsigned divisor magnitude (non-zero)
//   last_o       : the step being taken this cycle is the final one
//   quot_o/rem_o : quotient/remainder after this cycle's step (final values
//                  when last_o=1)
module div_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              last_o,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o
);

    logic [DATA_W-1:0] rem_q, quot_q, dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;

    logic [DATA_W:0]   rem_sh, diff;
    logic              fits;

    // quot_q starts as the dividend; its MSB shifts into the remainder while
    // quotient bits fill in from the bottom.
    always_comb begin
        rem_sh = {rem_q, quot_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        fits   = ~diff[DATA_W];
        rem_o  = fits ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quot_o = {quot_q[DATA_W-2:0], fits};
    end

    // 2^CNT_W == DATA_W, so an all-ones counter marks the final step.
    assign last_o = run_q && (&cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quot_q <= dividend_i;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            if (kill_i) begin
                run_q <= 1'b0;
            end else begin
                rem_q  <= rem_o;
                quot_q <= quot_o;
                cnt_q  <= cnt_q + 1'b1;
                if (last_o) run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_div.sv
// ex_div: multi-cycle RV32M DIV/DIVU/REM/REMU unit in the execute stage.
//   clk, rst   : clock, synchronous active-high reset
//   inst_i     : instruction from ID/EX
//   op1_i      : dividend (rs1)       op2_i : divisor (rs2)
//   rd_addr_i  : destination register from ID/EX
//   flush_i    : kills an in-flight divide, blocks a new start
//   result_o   : quotient/remainder, valid while wen_o=1 (holds otherwise)
//   rd_addr_o  : write-back destination, valid while wen_o=1
//   wen_o      : one-cycle write enable
//   hold_o     : pipeline stall request while the divide is accepted/running
//   busy_o     : unit not in IDLE
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] result_o,
    output logic [4:0]        rd_addr_o,
    output logic              wen_o,
    output logic              hold_o,
    output logic              busy_o
);

    state_e            state_q, state_d;
    logic              rem_op_q, rem_op_d;
    logic              s1_q, s1_d, s2_q, s2_d;
    logic [4:0]        rd_lat_q, rd_lat_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              wen_q, wen_d;

    logic [2:0]        f3;
    logic              is_div, start, op_signed, s1, s2, ovf, dvz, core_start;
    logic              core_last;
    logic [DATA_W-1:0] core_quot, core_rem;

    assign f3        = inst_i[14:12];
    assign is_div    = (inst_i[6:0] == INST_TYPE_R_M) && (inst_i[31:25] == FUNCT7_M) && f3[2];
    assign start     = is_div && (state_q == ST_IDLE) && !flush_i;
    assign op_signed = !f3[0];
    assign s1        = op_signed & op1_i[DATA_W-1];
    assign s2        = op_signed & op2_i[DATA_W-1];
    assign dvz       = (op2_i == '0);
    assign ovf       = op_signed && (op1_i == {1'b1, {(DATA_W-1){1'b0}}}) && (&op2_i);
    assign core_start = start && !dvz && !ovf;

    div_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (core_start),
        .kill_i     (flush_i),
        .dividend_i (neg_if(s1, op1_i)),
        .divisor_i  (neg_if(s2, op2_i)),
        .last_o     (core_last),
        .quot_o     (core_quot),
        .rem_o      (core_rem)
    );

    always_comb begin
        state_d  = state_q;
        rem_op_d = rem_op_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        rd_lat_d = rd_lat_q;
        rd_d     = rd_q;
        result_d = result_q;
        wen_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_op_d = f3[1];
                    s1_d     = s1;
                    s2_d     = s2;
                    rd_lat_d = rd_addr_i;
                    if (dvz || ovf) begin
                        // Results that need no iteration: written back next cycle.
                        if (dvz) result_d = f3[1] ? op1_i : '1;
                        else     result_d = f3[1] ? '0 : op1_i;
                        rd_d    = rd_addr_i;
                        wen_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (core_last) begin
                    // Remainder takes the dividend's sign, quotient the XOR.
                    result_d = rem_op_q ? neg_if(s1_q, core_rem)
                                        : neg_if(s1_q ^ s2_q, core_quot);
                    rd_d     = rd_lat_q;
                    wen_d    = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rem_op_q <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            rd_lat_q <= '0;
            rd_q     <= '0;
            result_q <= '0;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_op_q <= rem_op_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            rd_lat_q <= rd_lat_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            wen_q    <= wen_d;
        end
    end

    assign result_o  = result_q;
    assign rd_addr_o = rd_q;
    assign wen_o     = wen_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign hold_o    = !rst && (start || (state_q == ST_CALC));

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, op1_i, op2_i, result_o;
    logic [4:0]  rd_addr_i, rd_addr_o;
    logic        flush_i, wen_o, hold_o, busy_o;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ex_div dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .flush_i(flush_i), .result_o(result_o),
        .rd_addr_o(rd_addr_o), .wen_o(wen_o), .hold_o(hold_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_m(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Reference RV32M semantics; SV signed / and % truncate toward zero.
    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb_;
        sa = a; sb_ = b;
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : a;
        case (f3)
            3'b100:  return sa / sb_;
            3'b101:  return a / b;
            3'b110:  return sa % sb_;
            default: return a % b;
        endcase
    endfunction

    // Write-back monitor: every wen_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (wen_o) begin
            if (sb.size() == 0) begin
                chk("spurious_wen", 32'(wen_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("rd", 32'(rd_addr_o), 32'(e.rd));
                chk("wen_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        inst_i = mk_m(f3, rd); op1_i = a; op2_i = b; rd_addr_i = rd;
        sb.push_back('{exp, rd, cyc + lat});
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (hold_o) n++;
            else break;
            @(negedge clk);
            inst_i = NOP;
        end
        inst_i = NOP;
        chk("hold_cycles", n, lat);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        rst = 1'b1; inst_i = NOP; op1_i = 0; op2_i = 0; rd_addr_i = 0; flush_i = 0;
        repeat (3) @(negedge clk);
        #1 chk("rst_hold", 32'(hold_o), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_result", result_o, 0);
        chk("rst_rd", 32'(rd_addr_o), 0);
        chk("rst_wen", 32'(wen_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_hold2", 32'(hold_o), 0);

        // Normal and special paths
        issue(3'b101, 32'h64, 32'h7, 5'd5, 32'h0000_000E, 33);
        issue(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd6, 32'hFFFF_FFFD, 33);
        issue(3'b110, 32'hFFFF_FFF9, 32'h2, 5'd7, 32'hFFFF_FFFF, 33);
        issue(3'b100, 32'h1234, 32'h0, 5'd8, 32'hFFFF_FFFF, 1);
        issue(3'b111, 32'h1234, 32'h0, 5'd9, 32'h0000_1234, 1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1);
        issue(3'b110, 32'h7, 32'hFFFF_FFFE, 5'd0, 32'h0000_0001, 33);
        issue(3'b111, 32'hFFFF_FFFF, 32'h10, 5'd31, 32'h0000_000F, 33);

        for (int i = 0; i < 4; i++) begin
            rf3 = 3'($urandom_range(4, 7));
            ra = $urandom;
            rb = (i[0]) ? 32'($urandom_range(1, 300)) : $urandom;
            issue(rf3, ra, rb, 5'(i + 12), ref_m(rf3, ra, rb), 33);
        end

        // Flush in CALC: no write-back, idle the next cycle
        @(negedge clk);
        k = cyc;
        inst_i = mk_m(3'b101, 5'd3); op1_i = 32'h64; op2_i = 32'h7;
        @(negedge clk); inst_i = NOP;
        repeat (9) @(negedge clk);
        chk("flush_at_n10", cyc, k + 10);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_busy", 32'(busy_o), 0);
        chk("flush_hold", 32'(hold_o), 0);
        repeat (40) @(negedge clk);

        // Reset mid-operation
        inst_i = mk_m(3'b101, 5'd4); op1_i = 32'h1000; op2_i = 32'h3;
        @(negedge clk); inst_i = NOP;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_hold", 32'(hold_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_result", result_o, 0);
        chk("midrst_rd", 32'(rd_addr_o), 0);
        chk("midrst_wen", 32'(wen_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        repeat (40) @(negedge clk);
        issue(3'b101, 32'hFFFF_FFFF, 32'h1, 5'd17, 32'hFFFF_FFFF, 33);

        // Non-divide instructions never start: ADD, then MUL
        inst_i = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd1, 7'b0110011};
        #1 chk("add_hold", 32'(hold_o), 0);
        @(negedge clk);
        inst_i = mk_m(3'b000, 5'd1);
        #1 chk("mul_hold", 32'(hold_o), 0);
        @(negedge clk);
        inst_i = NOP;
        #1 chk("add_busy", 32'(busy_o), 0);
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
